// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: pipeline slot record, memory-wait FSM states
// and the register-match helper used by the hazard compare.
package hazard_pkg;

  localparam int REG_W = 4;

  typedef struct packed {
    logic             valid;
    logic             wb_en;
    logic             is_load;
    logic [REG_W-1:0] dest;
  } slot_t;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  localparam slot_t SLOT_EMPTY = '0;

  // True when an in-flight writer targets a register the ID instruction reads.
  function automatic logic slot_match(slot_t s, logic [REG_W-1:0] src1,
                                      logic [REG_W-1:0] src2, logic two_src);
    return s.valid & s.wb_en & ((s.dest == src1) | (two_src & (s.dest == src2)));
  endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// RUN/MEM_WAIT sequencer for multi-cycle data-memory accesses: drives freeze_pipe and the
// sticky timeout flag.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic mem_ready,
  output logic freeze_pipe,
  output logic mem_timeout_err
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_C = WCNT_W'(MEM_TIMEOUT);

  mem_state_t        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = '0;
    err_d       = err_q;
    freeze_pipe = 1'b0;
    case (state_q)
      RUN: begin
        // A single-cycle access (ready in the request cycle) never freezes.
        if (mem_req && !mem_ready) begin
          state_d     = MEM_WAIT;
          freeze_pipe = 1'b1;
        end
      end
      MEM_WAIT: begin
        freeze_pipe = !mem_ready;
        if (mem_ready) state_d = RUN;
        wcnt_d = (wcnt_q == TIMEOUT_C) ? wcnt_q : wcnt_q + 1'b1;
        // Flag only; the access is still waited out.
        if (wcnt_d == TIMEOUT_C) err_d = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_timeout_err = err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline scheduler beside ID: tracks EXE/MEM writers, raises RAW hazards, branch flushes and
// memory-wait freezes. Define HAZARD_FWD_EN when a forwarding unit exists (load-use stalls only).
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_W,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic                  id_wb_en,
  input  logic                  id_mem_r_en,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  hazard,
  output logic                  freeze_if,
  output logic                  flush_if_id,
  output logic                  flush_id_exe,
  output logic                  freeze_pipe,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic                  mem_timeout_err
);

  slot_t            exe_q, exe_d, mem_q, mem_d, id_slot;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             exe_hit, raw, flush;

  mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .freeze_pipe    (freeze_pipe),
    .mem_timeout_err(mem_timeout_err)
  );

  assign exe_hit = slot_match(exe_q, id_src1, id_src2, id_two_src);

`ifdef HAZARD_FWD_EN
  // Forwarding covers everything except a load whose data is not back yet.
  assign raw = exe_hit & exe_q.is_load;
  logic unused_slot_bits;
  assign unused_slot_bits = ^mem_q;
`else
  logic mem_hit;
  assign mem_hit = slot_match(mem_q, id_src1, id_src2, id_two_src);
  assign raw     = exe_hit | mem_hit;
  logic unused_slot_bits;
  assign unused_slot_bits = exe_q.is_load ^ mem_q.is_load;
`endif

  // A frozen EXE re-presents its branch after release, so frozen branches are ignored.
  assign flush        = branch_taken & ~freeze_pipe;
  assign flush_if_id  = flush;
  assign flush_id_exe = flush;
  assign hazard       = raw & ~flush & ~freeze_pipe;
  assign freeze_if    = hazard | freeze_pipe;

  always_comb begin
    id_slot         = SLOT_EMPTY;
    id_slot.valid   = 1'b1;
    id_slot.wb_en   = id_wb_en;
    id_slot.is_load = id_mem_r_en;
    id_slot.dest    = id_dest;
    exe_d = exe_q;
    mem_d = mem_q;
    if (!freeze_pipe) begin
      mem_d = exe_q;
      exe_d = (hazard || flush) ? SLOT_EMPTY : id_slot;
    end
    stall_d = stall_q;
    if ((hazard || freeze_pipe) && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q   <= SLOT_EMPTY;
      mem_q   <= SLOT_EMPTY;
      stall_q <= '0;
    end else begin
      exe_q   <= exe_d;
      mem_q   <= mem_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a default instance plus one with MEM_TIMEOUT=2 and a
// 3-bit stall counter, both driven by the same directed instruction stream.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  // Hazard expected only when any in-flight RAW stalls (no forwarding).
  localparam logic NF = !FWD;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1, id_src2, id_dest;
  logic       id_two_src, id_wb_en, id_mem_r_en, branch_taken, mem_req, mem_ready;

  logic        hazard, freeze_if, flush_if_id, flush_id_exe, freeze_pipe, mem_timeout_err;
  logic [15:0] stall_cycles;
  logic        hazard_t, freeze_if_t, flush_if_id_t, flush_id_exe_t, freeze_pipe_t, mem_timeout_err_t;
  logic [2:0]  stall_cycles_t;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .hazard(hazard), .freeze_if(freeze_if), .flush_if_id(flush_if_id),
    .flush_id_exe(flush_id_exe), .freeze_pipe(freeze_pipe), .stall_cycles(stall_cycles),
    .mem_timeout_err(mem_timeout_err)
  );

  pipe_hazard_ctrl #(.CNT_W(3), .MEM_TIMEOUT(2)) dut_t (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .hazard(hazard_t), .freeze_if(freeze_if_t), .flush_if_id(flush_if_id_t),
    .flush_id_exe(flush_id_exe_t), .freeze_pipe(freeze_pipe_t), .stall_cycles(stall_cycles_t),
    .mem_timeout_err(mem_timeout_err_t)
  );

  typedef struct {
    string nm;
    logic  hz;
    logic  fl;
    logic  fp;
    logic  et;
    int    st;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   model_s = 0;
  logic et = 1'b0;

  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s got=%0d exp=%0d", nm, f, act, exp);
    end
  endtask

  // Monitor: one expected record per driven cycle, compared mid-cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk(e.nm, "hazard",         32'(hazard),          32'(e.hz));
      chk(e.nm, "freeze_if",      32'(freeze_if),       32'(e.hz | e.fp));
      chk(e.nm, "flush_if_id",    32'(flush_if_id),     32'(e.fl));
      chk(e.nm, "flush_id_exe",   32'(flush_id_exe),    32'(e.fl));
      chk(e.nm, "freeze_pipe",    32'(freeze_pipe),     32'(e.fp));
      chk(e.nm, "stall_cycles",   32'(stall_cycles),    32'(e.st));
      chk(e.nm, "mem_timeout",    32'(mem_timeout_err), 32'(1'b0));
      chk(e.nm, "t.hazard",       32'(hazard_t),        32'(e.hz));
      chk(e.nm, "t.freeze_if",    32'(freeze_if_t),     32'(e.hz | e.fp));
      chk(e.nm, "t.flush_if_id",  32'(flush_if_id_t),   32'(e.fl));
      chk(e.nm, "t.flush_id_exe", 32'(flush_id_exe_t),  32'(e.fl));
      chk(e.nm, "t.freeze_pipe",  32'(freeze_pipe_t),   32'(e.fp));
      chk(e.nm, "t.stall_sat",    32'(stall_cycles_t),  32'((e.st > 7) ? 7 : e.st));
      chk(e.nm, "t.mem_timeout",  32'(mem_timeout_err_t), 32'(e.et));
    end
  end

  task automatic step(input string nm, input logic [3:0] s1, input logic [3:0] s2, input logic two,
                      input logic wb, input logic ld, input logic [3:0] dst, input logic br,
                      input logic mrq, input logic mrd, input logic ehz, input logic efl,
                      input logic efp);
    exp_t e;
    id_src1 = s1; id_src2 = s2; id_two_src = two; id_wb_en = wb; id_mem_r_en = ld;
    id_dest = dst; branch_taken = br; mem_req = mrq; mem_ready = mrd;
    e.nm = nm; e.hz = ehz; e.fl = efl; e.fp = efp; e.et = et; e.st = model_s;
    sb.push_back(e);
    if (ehz || efp) model_s++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input string nm);
    step(nm, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    id_src1 = '0; id_src2 = '0; id_two_src = 1'b0; id_wb_en = 1'b0; id_mem_r_en = 1'b0;
    id_dest = '0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    model_s = 0;
    et = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    do_reset(2);
    idle("reset_state");
    // ADD R1 then SUB R2,R1,R3
    step("t1_add",     4'd2, 4'd3, 1, 1, 0, 4'd1, 0, 0, 0, 1'b0, 0, 0);
    step("t1_sub_exe", 4'd1, 4'd3, 1, 1, 0, 4'd2, 0, 0, 0, NF,   0, 0);
    step("t1_sub_mem", 4'd1, 4'd3, 1, 1, 0, 4'd2, 0, 0, 0, NF,   0, 0);
    step("t1_sub_go",  4'd1, 4'd3, 1, 1, 0, 4'd2, 0, 0, 0, 1'b0, 0, 0);
    idle("t1_drain0"); idle("t1_drain1");
    // LDR R4 then ADD R5,R4,R4
    step("t2_ldr",     4'd0, 4'd0, 0, 1, 1, 4'd4, 0, 0, 0, 1'b0, 0, 0);
    step("t2_use_exe", 4'd4, 4'd4, 1, 1, 0, 4'd5, 0, 0, 0, 1'b1, 0, 0);
    step("t2_use_mem", 4'd4, 4'd4, 1, 1, 0, 4'd5, 0, 0, 0, NF,   0, 0);
    step("t2_use_go",  4'd4, 4'd4, 1, 1, 0, 4'd5, 0, 0, 0, 1'b0, 0, 0);
    idle("t2_drain0"); idle("t2_drain1");
    // condition-failed ADD R1 then readers of R1
    step("t3_cf_add",  4'd2, 4'd0, 0, 0, 0, 4'd1, 0, 0, 0, 1'b0, 0, 0);
    step("t3_use",     4'd1, 4'd1, 1, 0, 0, 4'd6, 0, 0, 0, 1'b0, 0, 0);
    step("t3_use2",    4'd1, 4'd1, 1, 0, 0, 4'd6, 0, 0, 0, 1'b0, 0, 0);
    idle("t3_drain0"); idle("t3_drain1");
    // branch flush beats a RAW hazard; flushed load R8 must not reach EXE
    step("t4_prod",    4'd0, 4'd0, 0, 1, 0, 4'd7, 0, 0, 0, 1'b0, 0, 0);
    step("t4_br",      4'd7, 4'd0, 0, 1, 1, 4'd8, 1, 0, 0, 1'b0, 1, 0);
    step("t4_chk",     4'd8, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 1'b0, 0, 0);
    idle("t4_drain0"); idle("t4_drain1");
    // 3-cycle memory wait with a load-use pending; slots must hold
    step("t5_ld",      4'd0, 4'd0, 0, 1, 1, 4'd9,  0, 0, 0, 1'b0, 0, 0);
    step("t5_req",     4'd9, 4'd0, 0, 1, 0, 4'd10, 0, 1, 0, 1'b0, 0, 1);
    step("t5_wait_br", 4'd9, 4'd0, 0, 1, 0, 4'd10, 1, 1, 0, 1'b0, 0, 1);
    step("t5_wait",    4'd9, 4'd0, 0, 1, 0, 4'd10, 0, 1, 0, 1'b0, 0, 1);
    et = 1'b1;
    step("t5_ready",   4'd9, 4'd0, 0, 1, 0, 4'd10, 0, 1, 1, 1'b1, 0, 0);
    step("t5_after",   4'd9, 4'd0, 0, 1, 0, 4'd10, 0, 0, 0, NF,   0, 0);
    step("t5_go",      4'd9, 4'd0, 0, 1, 0, 4'd10, 0, 0, 0, 1'b0, 0, 0);
    idle("t5_drain0"); idle("t5_drain1");
    // reset while in MEM_WAIT
    step("t6_req",     4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0, 1'b0, 0, 1);
    step("t6_wait",    4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0, 1'b0, 0, 1);
    do_reset(1);
    idle("t6_post");
    // long wait: 3-bit counter saturates, timeout flag re-arms after reset
    step("t7_req",     4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0, 1'b0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      if (i >= 2) et = 1'b1;
      step("t7_wait",  4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0, 1'b0, 0, 1);
    end
    step("t7_ready",   4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 1, 1'b0, 0, 0);
    idle("t7_end0"); idle("t7_end1");

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: %0d records left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
